// File: rtl/input_conditioner_if.sv
// input_conditioner_if
//   Groups the pin/timing inputs and the conditioned outputs of
//   input_conditioner. Clock and reset remain plain module ports.
//   Signals:
//     ui_in[7:0]     raw pins: [0] pause, [1] resume, [2] unused, [7:3] speed_6..speed_2
//     vsync          active-low vertical sync from vga_timing (same clock domain)
//     paused         1 = animation frozen; updated only at frame boundaries
//     step_size[2:0] pixels per frame, 1..6; updated only at frame boundaries
//     frame_tick     1-cycle pulse on the cycle vsync is first seen low
//     btn_state[7:0] debounced level of each ui_in bit
//   Modports:
//     master - the side that drives the pins and vsync (board / testbench)
//     slave  - the conditioner itself
interface input_conditioner_if;
  logic [7:0] ui_in;
  logic       vsync;
  logic       paused;
  logic [2:0] step_size;
  logic       frame_tick;
  logic [7:0] btn_state;

  modport master (
    output ui_in, vsync,
    input  paused, step_size, frame_tick, btn_state
  );

  modport slave (
    input  ui_in, vsync,
    output paused, step_size, frame_tick, btn_state
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner
//   Conditions the raw ui_in pins before they reach the pattern-control path:
//   two-flop synchroniser, per-bit debounce, pause/resume rising-edge detect,
//   run/pause state machine and speed priority encoding. The outputs paused
//   and step_size are reloaded only on frame_tick so the animation never
//   changes mid-frame.
//   Parameters:
//     DEBOUNCE_CYCLES  consecutive stable cycles before a new level is accepted
//     CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   Ports:
//     clk  - pixel clock, the only clock
//     rst  - synchronous, active-high reset
//     bus  - input_conditioner_if.slave (ui_in, vsync in; paused, step_size,
//            frame_tick, btn_state out)
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input_conditioner_if.slave   bus
);

  if ((2 ** CNT_W) <= DEBOUNCE_CYCLES || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("input_conditioner: CNT_W too small for DEBOUNCE_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] RUNNING = 1'b0;
  localparam logic [0:0] PAUSED  = 1'b1;

  logic [7:0]       sync_1;
  logic [7:0]       sync_2;
  logic [7:0]       btn_state;
  logic [7:0]       btn_prev;
  logic [CNT_W-1:0] cnt [8];
  logic [0:0]       run_state;
  logic             vsync_q;
  logic             paused_q;
  logic [2:0]       step_q;
  logic [2:0]       spd;
  logic             pause_rise;
  logic             resume_rise;
  logic             frame_tick;

  // Two-flop synchroniser; nothing else looks at ui_in.
  // NOTE: every clocked assignment is non-blocking so all flops sample the
  // pre-edge values together; a blocking '=' here would collapse the two
  // stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= bus.ui_in;
      sync_2 <= sync_1;
    end
  end

  // Per-bit debounce: a mismatch must persist for DEBOUNCE_CYCLES cycles
  // before btn_state follows; any return to the accepted level restarts it.
  // NOTE: the counter array is reset explicitly because a reset must discard
  // debounce progress; it is eight small registers, not a RAM, so this costs
  // nothing in inference.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_state <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync_2[i] == btn_state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          btn_state[i] <= sync_2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising-edge detect on the debounced pause/resume levels.
  always_ff @(posedge clk) begin
    if (rst) btn_prev <= '0;
    else     btn_prev <= btn_state;
  end

  assign pause_rise  = btn_state[0] & ~btn_prev[0];
  assign resume_rise = btn_state[1] & ~btn_prev[1];

  // Run/pause state; pause is checked first so it wins a same-cycle conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_state <= RUNNING;
    end else begin
      case (run_state)
        RUNNING: if (pause_rise)  run_state <= PAUSED;
        PAUSED:  if (!pause_rise && resume_rise) run_state <= RUNNING;
        default: run_state <= RUNNING;
      endcase
    end
  end

  // Speed priority encoder: highest speed pin wins, idle speed is 1.
  // NOTE: spd gets a default before the priority chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    spd = 3'd1;
    if      (btn_state[7]) spd = 3'd6;
    else if (btn_state[6]) spd = 3'd5;
    else if (btn_state[5]) spd = 3'd4;
    else if (btn_state[4]) spd = 3'd3;
    else if (btn_state[3]) spd = 3'd2;
  end

  // Frame boundary: the first low cycle of vsync.
  always_ff @(posedge clk) begin
    if (rst) vsync_q <= 1'b0;
    else     vsync_q <= bus.vsync;
  end

  assign frame_tick = vsync_q & ~bus.vsync;

  // Outputs are sampled from the FSM and encoder only at the frame boundary,
  // so presses within a frame collapse to whatever state holds at the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      paused_q <= 1'b0;
      step_q   <= 3'd1;
    end else if (frame_tick) begin
      paused_q <= (run_state == PAUSED);
      step_q   <= spd;
    end
  end

  assign bus.paused     = paused_q;
  assign bus.step_size  = step_q;
  assign bus.frame_tick = frame_tick;
  assign bus.btn_state  = btn_state;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Directed bench for input_conditioner with DEBOUNCE_CYCLES=4. Inputs are
//   driven 1 ns after the rising edge and outputs sampled at the same point.
module tb_input_conditioner;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one vsync low pulse and checks the tick and the reloaded outputs.
  task automatic do_frame(input logic exp_p, input logic [2:0] exp_s, input string name);
    bus.vsync = 1'b0;
    #1;
    checks++;
    if (bus.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL %s_tick: frame_tick=%b expected 1", name, bus.frame_tick);
    end
    step(1);
    checks++;
    if (bus.paused !== exp_p || bus.step_size !== exp_s) begin
      errors++;
      $display("FAIL %s_out: paused=%b step_size=%0d expected paused=%b step_size=%0d",
               name, bus.paused, bus.step_size, exp_p, exp_s);
    end
    checks++;
    if (bus.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s_tick_end: frame_tick=%b expected 0", name, bus.frame_tick);
    end
    bus.vsync = 1'b1;
    step(1);
  endtask

  task automatic check_out(input logic exp_p, input logic [2:0] exp_s, input string name);
    checks++;
    if (bus.paused !== exp_p || bus.step_size !== exp_s) begin
      errors++;
      $display("FAIL %s: paused=%b step_size=%0d expected paused=%b step_size=%0d",
               name, bus.paused, bus.step_size, exp_p, exp_s);
    end
  endtask

  task automatic check_btn(input logic [7:0] exp_b, input string name);
    checks++;
    if (bus.btn_state !== exp_b) begin
      errors++;
      $display("FAIL %s: btn_state=%h expected %h", name, bus.btn_state, exp_b);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.ui_in = 8'hFF;
    bus.vsync = 1'b1;
    step(3);
    check_out(1'b0, 3'd1, "reset_out");
    check_btn(8'h00, "reset_btn");
    checks++;
    if (bus.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick: frame_tick=%b expected 0", bus.frame_tick);
    end
    bus.ui_in = 8'h00;
    rst       = 1'b0;
    step(3);
    check_btn(8'h00, "reset_settle_btn");
  endtask

  task automatic test_glitch;
    bus.ui_in = 8'h01;
    step(3);
    bus.ui_in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_btn(8'h00, $sformatf("glitch_btn_%0d", i));
    end
    do_frame(1'b0, 3'd1, "glitch");
  endtask

  task automatic test_pause;
    bus.ui_in = 8'h01;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      check_btn((e == 6) ? 8'h01 : 8'h00, $sformatf("pause_edge_%0d", e));
    end
    step(3);
    check_out(1'b0, 3'd1, "pause_midframe");
    do_frame(1'b1, 3'd1, "pause");
  endtask

  task automatic test_speed;
    bus.ui_in = 8'h91;
    step(8);
    check_btn(8'h91, "speed6_btn");
    check_out(1'b1, 3'd1, "speed6_midframe");
    do_frame(1'b1, 3'd6, "speed6");
    bus.ui_in = 8'h11;
    step(3);
    check_out(1'b1, 3'd6, "speed3_debouncing");
    step(5);
    check_btn(8'h11, "speed3_btn");
    check_out(1'b1, 3'd6, "speed3_midframe");
    do_frame(1'b1, 3'd3, "speed3");
  endtask

  task automatic test_conflict;
    bus.ui_in = 8'h10;
    step(8);
    check_btn(8'h10, "conflict_release_btn");
    bus.ui_in = 8'h13;
    step(8);
    check_btn(8'h13, "conflict_both_btn");
    do_frame(1'b1, 3'd3, "conflict");
    bus.ui_in = 8'h10;
    step(8);
    bus.ui_in = 8'h12;
    step(8);
    check_btn(8'h12, "resume_btn");
    check_out(1'b1, 3'd3, "resume_midframe");
    do_frame(1'b0, 3'd3, "resume");
  endtask

  task automatic test_reset_mid_run;
    bus.ui_in = 8'h40;
    step(8);
    do_frame(1'b0, 3'd5, "speed5");
    bus.ui_in = 8'h41;
    step(3);
    rst = 1'b1;
    step(2);
    check_out(1'b0, 3'd1, "midrst_out");
    check_btn(8'h00, "midrst_btn");
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      check_btn((e == 6) ? 8'h41 : 8'h00, $sformatf("rearm_edge_%0d", e));
    end
    step(2);
    check_out(1'b0, 3'd1, "rearm_midframe");
    do_frame(1'b1, 3'd5, "rearm");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_pause();
    test_speed();
    test_conflict();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
